layer_par_mac: RTL and testbench
================================

LAYER_PAR_MAC -- requirements
Module: layer_par_mac

Interface
REQ-001 Parameter M, 16: output vector length (rows); SHALL be a multiple of P.
REQ-002 Parameter N, 12: input vector length (columns).
REQ-003 Parameter T, 20: signed two's-complement data width of inputs, weights, bias and outputs.
REQ-004 Parameter P, 2: parallel MAC lanes; rows computed per group.
REQ-005 Parameter FRAC, 0: arithmetic right shift applied to the accumulator before saturation.
REQ-006 Parameter ACT, 1: 1 = ReLU, 0 = identity activation.
REQ-007 clk  in  1  sole clock; all state updates on rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 s_valid  in  1  data_in word valid.
REQ-010 s_ready  out  1  block can accept a data_in word.
REQ-011 data_in  in  T  input vector element x[j], j = 0..N-1 in order.
REQ-012 m_valid  out  1  data_out word valid.
REQ-013 m_ready  in  1  downstream accepts data_out.
REQ-014 data_out  out  T  output element y[i], i = 0..M-1 in order.

Function
REQ-015 The block SHALL compute y[i] = act(sat_T((b[i] + sum_j W[i][j]*x[j]) >>> FRAC)) for each accepted N-word input vector.
REQ-016 Products SHALL be 2T bits; the accumulator SHALL be 2T+clog2(N+1) bits, wide enough that no intermediate overflow occurs.
REQ-017 sat_T SHALL clamp to [-2^(T-1), 2^(T-1)-1]; wrap-around SHALL NOT occur.
REQ-018 Input transfer SHALL occur only on a cycle with s_valid && s_ready; word k of a vector SHALL be written to x bank entry k.
REQ-019 x storage SHALL be double-buffered (2 banks of N words); s_ready SHALL be 1 whenever a bank is not full and not awaiting compute, including while the other bank is being computed.
REQ-020 When both banks are full or pending, s_ready SHALL be 0; it SHALL return to 1 the cycle after the compute engine releases a bank, i.e. after the last MAC read of that bank.
REQ-021 Compute FSM states: IDLE (no full bank) -> LOAD_B (bias read for group, 1 cycle) -> MAC (N cycles, P lanes, one column per cycle) -> DRAIN (2 cycles, ROM/multiplier pipeline) -> WAIT_OUT (holds until the output bank is empty) -> LOAD_B for the next group, or IDLE/LOAD_B of the next vector after group M/P-1.
REQ-022 Weights and bias SHALL be read from the ROM with one-cycle read latency; in MAC, lane p of group g SHALL use W[g*P+p][j].
REQ-023 Completed group results SHALL be stored in a P-entry output bank and emitted lane 0 first; the next group's MAC MAY overlap draining, but results SHALL NOT overwrite undrained entries.
REQ-024 m_valid SHALL be 1 while the output bank is non-empty; while m_valid && !m_ready, data_out and m_valid SHALL hold stable.
REQ-025 When m_valid is 0, data_out SHALL be 0.
REQ-026 Output order across back-to-back vectors SHALL be strictly vector-major, then row i ascending; no word SHALL be dropped or duplicated.
REQ-027 With no back-pressure, first output SHALL appear no later than N+4 cycles after the last input word of a vector is accepted.

Reset
REQ-028 While reset is 0: s_ready=0, m_valid=0, data_out=0, FSM=IDLE, both x banks empty, all counters 0, and partial vectors discarded.
REQ-029 Reset SHALL take effect asynchronously, including mid-MAC or mid-output; s_ready SHALL be 1 on the first clock edge after reset deasserts.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, the accumulator-width function and the saturate/activation function.
REQ-031 Weights and bias SHALL reside in one generated sub-module, layer_par_mac_rom, with address g*N+j and a P*T-bit weight row plus a P*T-bit bias word; the top SHALL contain no constant tables.

Verification
Bench ROM: M=4, N=3, P=2, T=16, FRAC=0, W[i][j]=i-1, b[i]=10*i.
REQ-032 Stimulus x=(1,2,3), ACT=1, m_ready=1 -> outputs 0,10,26,42 in order, then m_valid=0.
REQ-033 Stimulus x=(32767,32767,32767), ACT=0 -> -32768, 10, 32767, 32767; with ACT=1 -> 0, 10, 32767, 32767.
REQ-034 Stimulus x=(1,2,3), m_ready low for 5 cycles after first m_valid -> data_out held at 0 and m_valid held at 1; then the same 4 values are output with none lost.
REQ-035 Stimulus: two vectors (1,2,3) and (0,0,1) sent back-to-back with s_valid constant 1 -> no s_ready gap before word 4; outputs 0,10,26,42,0,10,21,32.
REQ-036 Stimulus: reset pulsed low during MAC of the first vector, then x=(1,2,3) -> no output from the aborted vector; outputs 0,10,26,42.

Source files
------------

// File: rtl/layer_par_mac_pkg.sv
// Shared types and arithmetic helpers for the parallel fully-connected layer MAC.
package layer_par_mac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_B,
    MAC,
    DRAIN,
    WAIT_OUT
  } state_t;

  // Product width plus enough headroom for N products and the bias.
  function automatic int acc_width(input int t, input int n);
    return 2 * t + $clog2(n + 1);
  endfunction

  // Clamp to the signed t-bit range, then optionally apply ReLU.
  function automatic logic signed [127:0] sat_act(input logic signed [127:0] v,
                                                  input int t, input logic relu);
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    logic signed [127:0] r;
    hi = (128'sd1 <<< (t - 1)) - 128'sd1;
    lo = -hi - 128'sd1;
    if (v > hi) r = hi;
    else if (v < lo) r = lo;
    else r = v;
    if (relu && (r < 0)) r = '0;
    return r;
  endfunction

endpackage

// File: rtl/layer_par_mac_rom.sv
// Generated weight/bias ROM: W[i][j] = i-1, b[i] = 10*i; one-cycle registered read.
module layer_par_mac_rom
  import layer_par_mac_pkg::*;
#(
  parameter int M  = 16,
  parameter int N  = 12,
  parameter int T  = 20,
  parameter int P  = 2,
  parameter int RW = 5
) (
  input  logic            clk,
  input  logic [RW-1:0]   addr,
  output logic [P*T-1:0]  w_row,
  output logic [P*T-1:0]  bias
);

  logic [P*T-1:0] w_next;
  logic [P*T-1:0] b_next;

  // Address g*N+j selects group g; every lane row is g*P+p, independent of j.
  always_comb begin
    w_next = '0;
    b_next = '0;
    for (int p = 0; p < P; p++) begin
      w_next[p*T +: T] = T'((int'(addr) / N) * P + p - 1);
      b_next[p*T +: T] = T'(10 * ((int'(addr) / N) * P + p));
    end
  end

  always_ff @(posedge clk) begin
    w_row <= w_next;
    bias  <= b_next;
  end

endmodule

// File: rtl/layer_par_mac.sv
// Matrix-vector layer: double-buffered input vector, P-lane MAC over row groups,
// saturating activation and a P-entry output bank drained one word at a time.
module layer_par_mac
  import layer_par_mac_pkg::*;
#(
  parameter int M    = 16,
  parameter int N    = 12,
  parameter int T    = 20,
  parameter int P    = 2,
  parameter int FRAC = 0,
  parameter int ACT  = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [T-1:0] data_in,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [T-1:0] data_out,
  output state_t       fsm_state
);

  localparam int G   = M / P;
  localparam int AW  = acc_width(T, N);
  localparam int XW  = (N > 1) ? $clog2(N) : 1;
  localparam int GW  = (G > 1) ? $clog2(G) : 1;
  localparam int RW  = (G * N > 1) ? $clog2(G * N) : 1;
  localparam int OW  = $clog2(P + 1);
  localparam int OIW = (P > 1) ? $clog2(P) : 1;

  // Handshake: a word moves on s_valid && s_ready, a result on m_valid && m_ready;
  // the source holds its word and valid stable until that cycle.

  logic signed [T-1:0]  xb [2][N];
  logic [1:0]           bank_full;
  logic                 wr_bank;
  logic [XW-1:0]        wr_idx;
  logic                 run;
  logic                 last_in;

  state_t               state;
  logic [GW-1:0]        g;
  logic [XW-1:0]        j;
  logic                 dcnt;
  logic                 rd_bank;
  logic                 rel;
  logic                 go;
  logic                 b1, v1, v2;
  logic signed [T-1:0]  x_q;
  logic signed [2*T-1:0] prod [P];
  logic signed [AW-1:0] acc [P];
  logic signed [T-1:0]  ob [P];
  logic signed [T-1:0]  res [P];
  logic [OW-1:0]        o_cnt;
  logic [OIW-1:0]       o_idx;
  logic [RW-1:0]        rom_addr;
  logic [P*T-1:0]       rom_w;
  logic [P*T-1:0]       rom_b;

  assign s_ready   = run && !bank_full[wr_bank];
  assign last_in   = s_valid && s_ready && (wr_idx == XW'(N - 1));
  assign rel       = (state == MAC) && (j == XW'(N - 1)) && (g == GW'(G - 1));
  // Start on the very edge that completes the bank to keep first-output latency at N+4.
  assign go        = bank_full[rd_bank] || (last_in && (wr_bank == rd_bank));
  assign m_valid   = (o_cnt != '0);
  assign data_out  = m_valid ? ob[o_idx] : '0;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (s_valid && s_ready) xb[wr_bank][wr_idx] <= data_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run       <= 1'b0;
      bank_full <= '0;
      wr_bank   <= 1'b0;
      wr_idx    <= '0;
    end else begin
      run <= 1'b1;
      if (rel) bank_full[rd_bank] <= 1'b0;
      if (s_valid && s_ready) begin
        if (wr_idx == XW'(N - 1)) begin
          bank_full[wr_bank] <= 1'b1;
          wr_bank            <= ~wr_bank;
          wr_idx             <= '0;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end
    end
  end

  always_comb begin
    rom_addr = '0;
    if (state == LOAD_B || state == MAC) rom_addr = RW'(int'(g) * N + int'(j));
  end

  layer_par_mac_rom #(.M(M), .N(N), .T(T), .P(P), .RW(RW)) u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .w_row(rom_w),
    .bias (rom_b)
  );

  always_comb begin
    for (int p = 0; p < P; p++)
      res[p] = T'(sat_act(128'(acc[p] >>> FRAC), T, ACT != 0));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      g       <= '0;
      j       <= '0;
      dcnt    <= 1'b0;
      rd_bank <= 1'b0;
      b1      <= 1'b0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      x_q     <= '0;
      o_cnt   <= '0;
      o_idx   <= '0;
      for (int p = 0; p < P; p++) begin
        prod[p] <= '0;
        acc[p]  <= '0;
        ob[p]   <= '0;
      end
    end else begin
      // Pipeline: ROM/x read -> multiply -> accumulate; bias seeds acc first.
      b1  <= (state == LOAD_B);
      v1  <= (state == MAC);
      v2  <= v1;
      x_q <= xb[rd_bank][j];
      for (int p = 0; p < P; p++) begin
        if (v1) prod[p] <= $signed(rom_w[p*T +: T]) * x_q;
        if (b1) acc[p] <= AW'($signed(rom_b[p*T +: T]));
        else if (v2) acc[p] <= acc[p] + AW'(prod[p]);
      end

      if (m_valid && m_ready) begin
        o_cnt <= o_cnt - 1'b1;
        o_idx <= o_idx + 1'b1;
      end

      case (state)
        IDLE: begin
          if (go) begin
            g     <= '0;
            j     <= '0;
            state <= LOAD_B;
          end
        end
        LOAD_B: state <= MAC;
        MAC: begin
          if (j == XW'(N - 1)) begin
            dcnt  <= 1'b0;
            state <= DRAIN;
            if (g == GW'(G - 1)) rd_bank <= ~rd_bank;
          end else begin
            j <= j + 1'b1;
          end
        end
        DRAIN: begin
          if (dcnt) state <= WAIT_OUT;
          else dcnt <= 1'b1;
        end
        WAIT_OUT: begin
          if (o_cnt == '0) begin
            for (int p = 0; p < P; p++) ob[p] <= res[p];
            o_cnt <= OW'(P);
            o_idx <= '0;
            j     <= '0;
            if (g == GW'(G - 1)) begin
              g     <= '0;
              state <= IDLE;
            end else begin
              g     <= g + 1'b1;
              state <= LOAD_B;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_par_mac.sv
// Directed bench for layer_par_mac with the small generated ROM (M=4, N=3, P=2, T=16).
module tb_layer_par_mac;
  import layer_par_mac_pkg::*;

  localparam int M = 4;
  localparam int N = 3;
  localparam int T = 16;
  localparam int P = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         s_valid = 1'b0;
  logic         m_ready = 1'b1;
  logic [T-1:0] data_in = '0;
  logic         s_ready_r, s_ready_i, m_valid_r, m_valid_i;
  logic [T-1:0] dout_r, dout_i;
  state_t       st_r, st_i;

  always #5 clk = ~clk;

  layer_par_mac #(.M(M), .N(N), .T(T), .P(P), .FRAC(0), .ACT(1)) dut_relu (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready_r), .data_in(data_in),
    .m_valid(m_valid_r), .m_ready(m_ready), .data_out(dout_r), .fsm_state(st_r)
  );

  layer_par_mac #(.M(M), .N(N), .T(T), .P(P), .FRAC(0), .ACT(0)) dut_id (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready_i), .data_in(data_in),
    .m_valid(m_valid_i), .m_ready(m_ready), .data_out(dout_i), .fsm_state(st_i)
  );

  int checks = 0;
  int errors = 0;
  logic [T-1:0] exp_q[$];
  logic [T-1:0] exp_id_q[$];
  logic [T-1:0] got_q[$];
  logic [T-1:0] got_id_q[$];

  typedef struct {
    logic [T-1:0] x[N];
    logic [T-1:0] y_relu[M];
    logic [T-1:0] y_id[M];
  } vec_t;
  vec_t tbl[5];

  // Output monitor, sampled just before the rising edge.
  always begin
    @(negedge clk);
    #4;
    if (m_valid_r && m_ready) got_q.push_back(dout_r);
    if (m_valid_i && m_ready) got_id_q.push_back(dout_i);
  end

  task automatic check(input string name, input logic [T-1:0] act, input logic [T-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  task automatic send_word(input logic [T-1:0] w);
    int k;
    k = 0;
    data_in = w;
    s_valid = 1'b1;
    while (!s_ready_r && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) check("s_ready_timeout", 16'(k), 16'(0));
    @(negedge clk);
  endtask

  task automatic send_vec(input logic [T-1:0] x0, input logic [T-1:0] x1,
                          input logic [T-1:0] x2);
    send_word(x0);
    send_word(x1);
    send_word(x2);
    s_valid = 1'b0;
  endtask

  task automatic push_exp(input int v);
    for (int i = 0; i < M; i++) begin
      exp_q.push_back(tbl[v].y_relu[i]);
      exp_id_q.push_back(tbl[v].y_id[i]);
    end
  endtask

  task automatic drain_check(input int n, input string tag);
    int k;
    logic [T-1:0] a;
    k = 0;
    while ((got_q.size() < n || got_id_q.size() < n) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_out_timeout"}, 16'(k < 300), 16'(1));
    for (int i = 0; i < n; i++) begin
      a = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      check($sformatf("%s_relu_y%0d", tag, i), a, exp_q.size() > 0 ? exp_q.pop_front() : '0);
      a = (got_id_q.size() > 0) ? got_id_q.pop_front() : 'x;
      check($sformatf("%s_id_y%0d", tag, i), a, exp_id_q.size() > 0 ? exp_id_q.pop_front() : '0);
    end
    repeat (4) @(negedge clk);
    check({tag, "_extra_words"}, 16'(got_q.size() + got_id_q.size()), 16'(0));
    check({tag, "_m_valid_idle"}, 16'(m_valid_r), 16'(0));
    check({tag, "_data_out_idle"}, dout_r, 16'(0));
  endtask

  initial begin
    int k;
    tbl[0].x = '{16'd1, 16'd2, 16'd3};
    tbl[0].y_relu = '{16'd0, 16'd10, 16'd26, 16'd42};
    tbl[0].y_id   = '{16'hFFFA, 16'd10, 16'd26, 16'd42};
    tbl[1].x = '{16'd32767, 16'd32767, 16'd32767};
    tbl[1].y_relu = '{16'd0, 16'd10, 16'd32767, 16'd32767};
    tbl[1].y_id   = '{16'h8000, 16'd10, 16'd32767, 16'd32767};
    tbl[2].x = '{16'h8000, 16'h8000, 16'h8000};
    tbl[2].y_relu = '{16'd32767, 16'd10, 16'd0, 16'd0};
    tbl[2].y_id   = '{16'd32767, 16'd10, 16'h8000, 16'h8000};
    tbl[3].x = '{16'd0, 16'd0, 16'd1};
    tbl[3].y_relu = '{16'd0, 16'd10, 16'd21, 16'd32};
    tbl[3].y_id   = '{16'hFFFF, 16'd10, 16'd21, 16'd32};
    tbl[4].x = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
    tbl[4].y_relu = '{16'd3, 16'd10, 16'd17, 16'd24};
    tbl[4].y_id   = '{16'd3, 16'd10, 16'd17, 16'd24};

    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", 16'(s_ready_r), 16'(0));
    check("rst_m_valid", 16'(m_valid_r), 16'(0));
    check("rst_data_out", dout_r, 16'(0));
    check("rst_state", 16'(st_r), 16'(IDLE));
    reset = 1'b1;
    @(negedge clk);
    check("rst_release_s_ready", 16'(s_ready_r), 16'(1));

    // Table-driven vectors with first-output latency bound
    for (int v = 0; v < 5; v++) begin
      push_exp(v);
      send_vec(tbl[v].x[0], tbl[v].x[1], tbl[v].x[2]);
      k = 0;
      while (!m_valid_r && k < 30) begin
        @(negedge clk);
        k++;
      end
      check($sformatf("vec%0d_latency_ok", v), 16'(k <= N + 4), 16'(1));
      drain_check(M, $sformatf("vec%0d", v));
    end

    // Back-pressure: first word must hold while m_ready is low
    m_ready = 1'b0;
    push_exp(0);
    send_vec(16'd1, 16'd2, 16'd3);
    k = 0;
    while (!m_valid_r && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("bp_first_valid", 16'(m_valid_r), 16'(1));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_hold_valid_%0d", c), 16'(m_valid_r), 16'(1));
      check($sformatf("bp_hold_relu_%0d", c), dout_r, 16'(0));
      check($sformatf("bp_hold_id_%0d", c), dout_i, 16'hFFFA);
    end
    m_ready = 1'b1;
    drain_check(M, "bp");

    // Back-to-back vectors with s_valid held high
    push_exp(0);
    push_exp(3);
    s_valid = 1'b1;
    for (int w = 0; w < 2 * N; w++) begin
      data_in = (w < N) ? tbl[0].x[w] : tbl[3].x[w - N];
      check($sformatf("b2b_s_ready_w%0d", w), 16'(s_ready_r), 16'(1));
      @(negedge clk);
    end
    s_valid = 1'b0;
    drain_check(2 * M, "b2b");

    // Reset in the middle of MAC discards the vector
    send_vec(16'd1, 16'd2, 16'd3);
    repeat (2) @(negedge clk);
    check("abort_in_mac", 16'(st_r), 16'(MAC));
    reset = 1'b0;
    #1;
    check("abort_s_ready", 16'(s_ready_r), 16'(0));
    check("abort_m_valid", 16'(m_valid_r), 16'(0));
    check("abort_state", 16'(st_r), 16'(IDLE));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_release_s_ready", 16'(s_ready_r), 16'(1));
    repeat (20) @(negedge clk);
    check("abort_no_output", 16'(got_q.size() + got_id_q.size()), 16'(0));
    push_exp(0);
    send_vec(16'd1, 16'd2, 16'd3);
    drain_check(M, "after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout got %0d expected %0d", checks, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
